// File: rtl/bp_pkg.sv
// Shared types and constants for the branch history table.
//   ctrState_t      : 2-bit saturating counter state (SNT/WNT/WT/ST)
//   DEFAULT_ENTRIES : default number of table entries
package bp_pkg;

    localparam int unsigned PC_W            = 32;
    localparam int unsigned CTR_W           = 2;
    localparam int unsigned DEFAULT_ENTRIES = 64;

    typedef enum logic [CTR_W-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctrState_t;

endpackage

// File: rtl/branch_history_table_if.sv
// Pipeline-side signals of the branch history table.
//   master : pipeline (drives lookup PC, stall/flush, branch resolution; reads BPD)
//   slave  : the table itself
interface branch_history_table_if;
    import bp_pkg::*;

    logic [PC_W-1:0] PCF;
    logic            StallD;
    logic            FlushD;
    logic            BranchB;
    logic [PC_W-1:0] PCB;
    logic            TakenB;
    logic            BPD;

    modport master (
        output PCF, StallD, FlushD, BranchB, PCB, TakenB,
        input  BPD
    );

    modport slave (
        input  PCF, StallD, FlushD, BranchB, PCB, TakenB,
        output BPD
    );
endinterface

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
//   state       : current counter state
//   taken       : resolved branch outcome (1 = taken)
//   nextState_c : combinational next state, saturating at SNT and ST
module sat_counter2
    import bp_pkg::*;
(
    input  ctrState_t state,
    input  logic      taken,
    output ctrState_t nextState_c
);

    // Step one state toward the outcome, clamping at both ends.
    always_comb begin
        nextState_c = state;
        case (state)
            SNT:     nextState_c = taken ? WNT : SNT;
            WNT:     nextState_c = taken ? WT  : SNT;
            WT:      nextState_c = taken ? ST  : WNT;
            ST:      nextState_c = taken ? ST  : WT;
            default: nextState_c = state;
        endcase
    end

endmodule

// File: rtl/branch_history_table.sv
// Bimodal branch predictor: ENTRIES 2-bit counters indexed by PC[IDXW+1:2].
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset (counters -> WNT, BPD -> 0)
//   bus   : slave side of branch_history_table_if
//           (PCF lookup, StallD/FlushD for BPD, BranchB/PCB/TakenB training, BPD out)
module branch_history_table
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = DEFAULT_ENTRIES,
    parameter int unsigned IDXW    = $clog2(ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_history_table_if.slave  bus
);

    ctrState_t       ctrTable [ENTRIES];
    logic [IDXW-1:0] iF;
    logic [IDXW-1:0] iB;
    ctrState_t       curB;
    ctrState_t       nextB_c;
    logic            predF_c;
    logic            bpdQ;
    logic            unusedPcBits;

    assign iF   = bus.PCF[IDXW+1:2];
    assign iB   = bus.PCB[IDXW+1:2];
    assign curB = ctrTable[iB];

    // Byte offset and upper PC bits do not take part in indexing; aliasing is intended.
    assign unusedPcBits = ^{bus.PCF[PC_W-1:IDXW+2], bus.PCF[1:0],
                            bus.PCB[PC_W-1:IDXW+2], bus.PCB[1:0]};

    sat_counter2 uSatCounter (
        .state       (curB),
        .taken       (bus.TakenB),
        .nextState_c (nextB_c)
    );

    // Write-first bypass: a lookup hitting the entry being trained sees the new value.
    assign predF_c = (bus.BranchB && (iB == iF)) ? nextB_c[1] : ctrTable[iF][1];

    // Counter storage; training is independent of decode stall/flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctrTable[i] <= WNT;
            end
        end else if (bus.BranchB) begin
            ctrTable[iB] <= nextB_c;
        end
    end

    // Decode-stage prediction register; flush wins over stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bpdQ <= 1'b0;
        end else if (bus.FlushD) begin
            bpdQ <= 1'b0;
        end else if (!bus.StallD) begin
            bpdQ <= predF_c;
        end
    end

    assign bus.BPD = bpdQ;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table (ENTRIES = 64, index = PC[7:2]).
module tb_branch_history_table;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFails;

    logic  expQ [$];
    string tagQ [$];

    logic [1:0] mCtr [64];
    logic       mBpd;

    branch_history_table_if bus ();

    branch_history_table #(.ENTRIES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", nChecks, nFails);
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic actual, input logic expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("FAIL %s: BPD=%0b expected %0b (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs, queue the expected BPD, compare after the edge.
    task automatic step(input logic [31:0] pcf, input logic stall, input logic flush,
                        input logic br, input logic [31:0] pcb, input logic tk,
                        input logic expBpd, input string tag);
        bus.PCF     = pcf;
        bus.StallD  = stall;
        bus.FlushD  = flush;
        bus.BranchB = br;
        bus.PCB     = pcb;
        bus.TakenB  = tk;
        expQ.push_back(expBpd);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        checkEq(tagQ.pop_front(), bus.BPD, expQ.pop_front());
    endtask

    // Reset with a taken branch presented throughout; it must be ignored.
    task automatic doReset();
        @(posedge clk);
        #1;
        bus.BranchB = 1'b1;
        bus.TakenB  = 1'b1;
        bus.PCB     = 32'h0;
        bus.PCF     = 32'h0;
        reset       = 1'b0;
        #1;
        checkEq("rst_async", bus.BPD, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset       = 1'b1;
        bus.BranchB = 1'b0;
        bus.TakenB  = 1'b0;
    endtask

    // Reference step: apply the update first, then read; equals write-first bypass.
    function automatic logic modelStep(input logic [31:0] pcf, input logic stall,
                                       input logic flush, input logic br,
                                       input logic [31:0] pcb, input logic tk);
        logic [5:0] fi;
        logic [5:0] bi;
        fi = pcf[7:2];
        bi = pcb[7:2];
        if (br) begin
            if (tk && mCtr[bi] != 2'b11)      mCtr[bi] = mCtr[bi] + 2'd1;
            else if (!tk && mCtr[bi] != 2'b00) mCtr[bi] = mCtr[bi] - 2'd1;
        end
        if (flush)       mBpd = 1'b0;
        else if (!stall) mBpd = mCtr[fi][1];
        return mBpd;
    endfunction

    initial begin
        nChecks     = 0;
        nFails      = 0;
        reset       = 1'b0;
        bus.PCF     = 32'h0;
        bus.StallD  = 1'b0;
        bus.FlushD  = 1'b0;
        bus.BranchB = 1'b0;
        bus.PCB     = 32'h0;
        bus.TakenB  = 1'b0;
        #12;
        reset = 1'b1;

        // Initial state: WNT everywhere
        doReset();
        step(32'h100, 0, 0, 0, 32'h0, 0, 1'b0, "init_wnt_100");
        step(32'h0FC, 0, 0, 0, 32'h0, 0, 1'b0, "init_wnt_0fc");

        // Train entry of 0x100 while looking elsewhere (no bypass)
        step(32'h004, 0, 0, 1, 32'h100, 1, 1'b0, "upd_t1_other");
        step(32'h100, 0, 0, 0, 32'h0,   0, 1'b1, "wt_after_t1");
        step(32'h004, 0, 0, 1, 32'h100, 1, 1'b0, "upd_t2_other");
        step(32'h100, 0, 0, 0, 32'h0,   0, 1'b1, "st_after_t2");
        step(32'h004, 0, 0, 1, 32'h100, 0, 1'b0, "upd_nt1_other");
        step(32'h100, 0, 0, 0, 32'h0,   0, 1'b1, "wt_after_nt1");
        step(32'h004, 0, 0, 1, 32'h100, 0, 1'b0, "upd_nt2_other");
        step(32'h100, 0, 0, 0, 32'h0,   0, 1'b0, "wnt_after_nt2");
        step(32'h004, 0, 0, 0, 32'h100, 1, 1'b0, "br0_ignored");
        step(32'h100, 0, 0, 0, 32'h0,   0, 1'b0, "br0_no_train");

        // Saturation at ST and SNT
        doReset();
        for (int i = 0; i < 4; i++) step(32'h004, 0, 0, 1, 32'h200, 1, 1'b0, "sat_t_other");
        step(32'h200, 0, 0, 0, 32'h0,   0, 1'b1, "sat_st");
        step(32'h004, 0, 0, 1, 32'h200, 0, 1'b0, "sat_nt_other");
        step(32'h200, 0, 0, 0, 32'h0,   0, 1'b1, "sat_hi_no_wrap");
        for (int i = 0; i < 4; i++) step(32'h004, 0, 0, 1, 32'h200, 0, 1'b0, "sat_nt_other");
        step(32'h200, 0, 0, 0, 32'h0,   0, 1'b0, "sat_snt");
        step(32'h004, 0, 0, 1, 32'h200, 1, 1'b0, "sat_t_other");
        step(32'h200, 0, 0, 0, 32'h0,   0, 1'b0, "sat_lo_no_wrap");
        step(32'h004, 0, 0, 1, 32'h200, 1, 1'b0, "sat_t_other");
        step(32'h200, 0, 0, 0, 32'h0,   0, 1'b1, "snt_climb_wt");

        // Same-cycle update and lookup
        doReset();
        step(32'h300, 0, 0, 1, 32'h300, 1, 1'b1, "bypass_taken");
        step(32'h300, 0, 0, 1, 32'h300, 0, 1'b0, "bypass_not_taken");

        // Stall hold, training during stall, flush priority
        step(32'h300, 0, 0, 1, 32'h300, 1, 1'b1, "bypass_again");
        step(32'h004, 1, 0, 0, 32'h0,   0, 1'b1, "stall_hold1");
        step(32'h008, 1, 0, 0, 32'h0,   0, 1'b1, "stall_hold2");
        step(32'h004, 1, 0, 1, 32'h004, 1, 1'b1, "stall_hold3");
        step(32'h300, 1, 1, 0, 32'h0,   0, 1'b0, "flush_over_stall");
        step(32'h004, 0, 0, 0, 32'h0,   0, 1'b1, "train_during_stall");
        step(32'h300, 0, 1, 0, 32'h0,   0, 1'b0, "flush_only");
        step(32'h300, 0, 0, 0, 32'h0,   0, 1'b1, "after_flush");

        // Aliasing and reset discarding training
        doReset();
        step(32'h000, 0, 0, 1, 32'h004, 1, 1'b0, "alias_upd");
        step(32'h104, 0, 0, 0, 32'h0,   0, 1'b1, "alias_104");
        step(32'hFFFF_FF07, 0, 0, 0, 32'h0, 0, 1'b1, "alias_high_bits");
        doReset();
        step(32'h104, 0, 0, 0, 32'h0,   0, 1'b0, "rst_discard");

        // Randomised traffic against the reference model
        doReset();
        for (int i = 0; i < 64; i++) mCtr[i] = 2'b01;
        mBpd = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pf;
            logic [31:0] pb;
            logic        st;
            logic        fl;
            logic        br;
            logic        tk;
            logic        ex;
            pf = ($urandom & ~32'h0000_00FC) | (32'($urandom_range(0, 3)) << 2);
            pb = ($urandom & ~32'h0000_00FC) | (32'($urandom_range(0, 3)) << 2);
            st = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 9) == 0);
            br = ($urandom_range(0, 2) != 0);
            tk = 1'($urandom_range(0, 1));
            ex = modelStep(pf, st, fl, br, pb, tk);
            step(pf, st, fl, br, pb, tk, ex, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 SHALL provide parameter ENTRIES, default 64, number of 2-bit counters; power of two, 4..1024.
REQ-002 SHALL provide parameter IDXW, default $clog2(ENTRIES), index width taken from PC[IDXW+1:2].
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PCF  input  32  fetch-stage PC used for lookup.
REQ-006 SHALL have port StallD  input  1  hold the decode-stage prediction register.
REQ-007 SHALL have port FlushD  input  1  clear the decode-stage prediction register.
REQ-008 SHALL have port BranchB  input  1  a conditional branch is resolving in the branch stage this cycle.
REQ-009 SHALL have port PCB  input  32  PC of the resolving branch.
REQ-010 SHALL have port TakenB  input  1  actual outcome of the resolving branch (1 = taken).
REQ-011 SHALL have port BPD  output  1  registered prediction for the instruction in decode (1 = predict taken); feeds the control-unit pipeline.

Function
REQ-012 SHALL hold ENTRIES counters with states SNT=00, WNT=01, WT=10, ST=11.
REQ-013 SHALL compute lookup index iF = PCF[IDXW+1:2] and update index iB = PCB[IDXW+1:2]; PC bits [1:0] and above IDXW+1 are ignored (aliasing permitted).
REQ-014 SHALL form combinational prediction predF = bit 1 of counter[iF].
REQ-015 SHALL, when BranchB=1 and TakenB=1, increment counter[iB] at the clock edge, saturating at ST.
REQ-016 SHALL, when BranchB=1 and TakenB=0, decrement counter[iB] at the clock edge, saturating at SNT.
REQ-017 SHALL leave all counters unchanged when BranchB=0, regardless of TakenB/PCB.
REQ-018 SHALL, when BranchB=1 and iB==iF in the same cycle, derive predF from the post-update counter value (write-first bypass).
REQ-019 SHALL register predF into BPD at each clock edge: FlushD=1 -> BPD<=0; else StallD=1 -> BPD holds; else BPD<=predF.
REQ-020 SHALL give FlushD priority over StallD when both are asserted.
REQ-021 SHALL keep counter updates independent of StallD/FlushD (a resolving branch always trains the table).
REQ-022 SHALL give a lookup-to-BPD latency of exactly one cycle and an update-to-visible latency of zero cycles via bypass, one cycle otherwise.

Reset
REQ-023 SHALL, while reset=0, force BPD=0 and all counters to WNT, asynchronously.
REQ-024 SHALL ignore BranchB during reset; the first update is accepted on the first rising edge after reset deasserts.
REQ-025 SHALL, on reset asserted mid-operation, discard all training; no partial update is permitted.

Structure
REQ-026 SHALL take the counter state encoding (SNT/WNT/WT/ST typedef) and the default ENTRIES constant from a shared package bp_pkg.
REQ-027 SHALL implement the saturating next-state function in one sub-module, sat_counter2 (inputs: state, taken; output: next state), instantiated once on the update path.
REQ-028 SHALL contain no other sub-modules; table storage is flip-flops (ENTRIES x 2 bits) with async reset.

Verification
REQ-029 SHALL cover: reset then PCF=0x100 for all entries -> BPD=0 one cycle later (WNT everywhere).
REQ-030 SHALL cover: BranchB=1, PCB=0x100, TakenB=1 once -> lookup of PCF=0x100 gives BPD=1 next cycle; a second taken update -> ST; two not-taken updates -> WNT, BPD=0.
REQ-031 SHALL cover: four consecutive taken updates on PCB=0x200 -> counter stays ST (saturation); five not-taken -> SNT, no wrap to ST.
REQ-032 SHALL cover: same-cycle BranchB=1, PCB=0x300, TakenB=1 with PCF=0x300 from WNT -> BPD=1 on the next edge (bypass).
REQ-033 SHALL cover: BPD=1 held with StallD=1 for 3 cycles while PCF changes to a WNT entry -> BPD stays 1; FlushD=StallD=1 -> BPD=0.
REQ-034 SHALL cover: aliasing, with ENTRIES=64 a taken update at PCB=0x004 makes PCF=0x104 predict taken; reset asserted between update and lookup -> BPD=0.
